seg_display_capture: RTL and testbench

- Receive-side counterpart of the team's multiplexed 7-segment driver.
- Monitors the segment bus and one-hot digit strobes produced by a strobed display driver, or by external display pins.
- Decodes each settled digit pattern back to a hex nibble, assembles a full frame and reports it with a one-cycle valid strobe.
- Used for loopback self-test of display paths and for sniffing display boards under test.

---
 rtl/seg_display_pkg.sv | 24 ++
 rtl/seg_pattern_decode.sv | 25 ++
 rtl/seg_display_capture.sv | 191 +++++++++++++++++++
 tb/tb_seg_display_capture.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared 7-segment constants, capture FSM states and per-digit slot record.
package seg_display_pkg;

   localparam int SEG_DP_BIT = 7;

   // gfedcba patterns for hex digits 0..F, shared with the display driver
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef logic [1:0] cap_state_t;
   localparam cap_state_t ST_IDLE     = 2'd0;
   localparam cap_state_t ST_SETTLING = 2'd1;
   localparam cap_state_t ST_CAPTURED = 2'd2;

   typedef struct packed {
      logic [3:0] nibble;
      logic       blank;
      logic       dp;
      logic       err;
   } slot_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps a gfedcba pattern to its hex nibble, flagging dark and undecodable patterns.
module seg_pattern_decode (
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       blank,
   output logic       err
);
   import seg_display_pkg::*;

   logic hit;

   // table search; a dark digit decodes to 0 and is not an error
   always_comb begin
      nibble = '0;
      hit    = 1'b0;
      for (int i = 0; i < 16; i++)
         if (pattern == HEX_SEG[i]) begin
            nibble = 4'(i);
            hit    = 1'b1;
         end
      blank = pattern == 7'h00;
      err   = !hit && !blank;
   end

endmodule

// File: rtl/seg_display_capture.sv
// seg_display_capture: decodes multiplexed 7-segment strobes back into frames; SEG_DISPLAY_CAPTURE_SYNC_EN adds 2-flop input synchronisers.
module seg_display_capture #(
   parameter int SEGS             = 3,
   parameter int SETTLE_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES   = 5000000,
   parameter int SEG_ACTIVE_LOW   = 0,
   parameter int DIGIT_ACTIVE_LOW = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             seg_in,
   input  logic [SEGS-1:0]        digit_in,
   output logic [4*SEGS-1:0]      data_out,
   output logic [SEGS-1:0]        blank_mask,
   output logic                   dp_present,
   output logic [$clog2(SEGS):0]  dp_location,
   output logic                   pattern_error,
   output logic                   data_valid,
   output logic                   stale
);
   import seg_display_pkg::*;

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int LW = $clog2(SEGS) + 1;
   localparam logic [SW-1:0] SETTLE_N  = SW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_N = TW'(TIMEOUT_CYCLES);

   logic [7:0]          seg_s, seg_n;
   logic [SEGS-1:0]     dig_s, dig_n;
   logic [SEGS+7:0]     cur, prev;
   logic                same, onehot, cap, tick;
   cap_state_t          state, state_d;
   logic [SW-1:0]       cnt, cnt_d, cnt_inc;
   logic [TW-1:0]       tcnt;
   logic [SEGS-1:0]     mask;
   slot_t [SEGS-1:0]    slots;
   slot_t               new_slot;
   logic [3:0]          dec_nib;
   logic                dec_blank, dec_err;
   logic [4*SEGS-1:0]   f_data;
   logic [SEGS-1:0]     f_blank;
   logic                f_dp, f_err;
   logic [LW-1:0]       f_loc;

`ifdef SEG_DISPLAY_CAPTURE_SYNC_EN
   logic [7:0]      seg_m;
   logic [SEGS-1:0] dig_m;

   // two-flop synchroniser for an asynchronous display source
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         seg_m <= '0;
         seg_s <= '0;
         dig_m <= '0;
         dig_s <= '0;
      end else begin
         seg_m <= seg_in;
         seg_s <= seg_m;
         dig_m <= digit_in;
         dig_s <= dig_m;
      end
`else
   assign seg_s = seg_in;
   assign dig_s = digit_in;
`endif

   assign seg_n   = (SEG_ACTIVE_LOW != 0) ? ~seg_s : seg_s;
   assign dig_n   = (DIGIT_ACTIVE_LOW != 0) ? ~dig_s : dig_s;
   assign cur     = {seg_n, dig_n};
   assign same    = cur == prev;
   assign onehot  = (dig_n != '0) && ((dig_n & (dig_n - SEGS'(1))) == '0);
   assign cnt_inc = (cnt == SETTLE_N) ? cnt : cnt + SW'(1);
   assign tick    = (mask != '0) || (state == ST_IDLE);

   seg_pattern_decode u_dec (
      .pattern (seg_n[6:0]),
      .nibble  (dec_nib),
      .blank   (dec_blank),
      .err     (dec_err)
   );

   assign new_slot = {dec_nib, dec_blank, seg_n[SEG_DP_BIT], dec_err};

   // settle FSM: a digit is accepted once per dwell after SETTLE_CYCLES identical samples
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      cap     = 1'b0;
      case (state)
         ST_IDLE: begin
            state_d = onehot ? ST_SETTLING : ST_IDLE;
            cnt_d   = onehot ? SW'(1) : '0;
         end
         ST_SETTLING:
            if (!onehot) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (!same) begin
               cnt_d = SW'(1);
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == SETTLE_N) begin
                  cap     = 1'b1;
                  state_d = ST_CAPTURED;
               end
            end
         ST_CAPTURED:
            if (!same) begin
               state_d = onehot ? ST_SETTLING : ST_IDLE;
               cnt_d   = onehot ? SW'(1) : '0;
            end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // state, settle counter and previous-sample register
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         prev  <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         prev  <= cur;
      end

   // flatten the slot buffer into frame values; descending scan makes the lowest lit dp win
   always_comb begin
      f_data  = '0;
      f_blank = '0;
      f_err   = 1'b0;
      f_dp    = 1'b0;
      f_loc   = '0;
      for (int i = SEGS - 1; i >= 0; i--) begin
         f_data[4*i +: 4] = slots[i].nibble;
         f_blank[i]       = slots[i].blank;
         f_err            = f_err | slots[i].err;
         if (slots[i].dp) begin
            f_dp  = 1'b1;
            f_loc = LW'(i);
         end
      end
   end

   // slot writes, timeout supervision and frame hand-off one cycle after the mask fills
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         slots         <= '0;
         mask          <= '0;
         tcnt          <= TIMEOUT_N;
         stale         <= 1'b0;
         data_valid    <= 1'b0;
         data_out      <= '0;
         blank_mask    <= '0;
         dp_present    <= 1'b0;
         dp_location   <= '0;
         pattern_error <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (cap) begin
            for (int i = 0; i < SEGS; i++)
               if (dig_n[i]) slots[i] <= new_slot;
            mask <= mask | dig_n;
            tcnt <= TIMEOUT_N;
         end else if (tick) begin
            if (tcnt == '0) begin
               mask  <= '0;
               stale <= 1'b1;
               tcnt  <= TIMEOUT_N;
            end else begin
               tcnt <= tcnt - TW'(1);
            end
         end
         if (&mask) begin
            mask          <= '0;
            stale         <= 1'b0;
            data_valid    <= 1'b1;
            data_out      <= f_data;
            blank_mask    <= f_blank;
            dp_present    <= f_dp;
            dp_location   <= f_loc;
            pattern_error <= f_err;
         end
      end

endmodule

// File: tb/tb_seg_display_capture.sv
// tb_seg_display_capture: table-driven frame vectors plus directed glitch, timeout and reset sequences.
module tb_seg_display_capture;

   localparam int SEGS = 3;
   localparam int LW   = $clog2(SEGS) + 1;

   typedef struct packed {
      logic [2:0][2:0] dig;
      logic [2:0][7:0] seg;
      logic [11:0]     data;
      logic [2:0]      blank;
      logic            dp;
      logic [LW-1:0]   loc;
      logic            perr;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        seg_in = '0;
   logic [SEGS-1:0]   digit_in = '0;
   logic [4*SEGS-1:0] data_out;
   logic [SEGS-1:0]   blank_mask;
   logic              dp_present;
   logic [LW-1:0]     dp_location;
   logic              pattern_error, data_valid, stale;

   int checks = 0, fails = 0, cyc = 0, vcount = 0, vcyc = 0;
   vec_t vecs [5];

   seg_display_capture #(
      .SEGS(SEGS), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100),
      .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .digit_in(digit_in),
      .data_out(data_out), .blank_mask(blank_mask), .dp_present(dp_present),
      .dp_location(dp_location), .pattern_error(pattern_error),
      .data_valid(data_valid), .stale(stale)
   );

   always #5 clk = ~clk;

   // edge counter used to time data_valid against stimulus
   always @(posedge clk) cyc <= cyc + 1;

   // count valid strobes, sampled away from the active edge
   always @(negedge clk)
      if (data_valid) begin
         vcount <= vcount + 1;
         vcyc   <= cyc;
      end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic hold(input logic [2:0] d, input logic [7:0] s, input int n);
      digit_in = d;
      seg_in   = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data"}, 32'(data_out), 0);
      chk({tag, "_blank"}, 32'(blank_mask), 0);
      chk({tag, "_dp"}, 32'(dp_present), 0);
      chk({tag, "_loc"}, 32'(dp_location), 0);
      chk({tag, "_perr"}, 32'(pattern_error), 0);
      chk({tag, "_valid"}, 32'(data_valid), 0);
      chk({tag, "_stale"}, 32'(stale), 0);
   endtask

   function automatic vec_t mk(input logic [2:0] d0, input logic [7:0] s0,
                               input logic [2:0] d1, input logic [7:0] s1,
                               input logic [2:0] d2, input logic [7:0] s2,
                               input logic [11:0] data, input logic [2:0] blank,
                               input logic dp, input logic [LW-1:0] loc, input logic perr);
      vec_t v;
      v.dig   = {d2, d1, d0};
      v.seg   = {s2, s1, s0};
      v.data  = data;
      v.blank = blank;
      v.dp    = dp;
      v.loc   = loc;
      v.perr  = perr;
      return v;
   endfunction

   initial begin
      int v0, st;
      vecs[0] = mk(3'b001, 8'h4F, 3'b010, 8'h5B, 3'b100, 8'h06, 12'h123, 3'b000, 1'b0, 3'd0, 1'b0);
      vecs[1] = mk(3'b100, 8'h00, 3'b010, 8'hDB, 3'b001, 8'h3F, 12'h020, 3'b100, 1'b1, 3'd1, 1'b0);
      vecs[2] = mk(3'b001, 8'h49, 3'b010, 8'h5B, 3'b100, 8'h5B, 12'h220, 3'b000, 1'b0, 3'd0, 1'b1);
      vecs[3] = mk(3'b100, 8'hF1, 3'b010, 8'h7C, 3'b001, 8'hF7, 12'hFBA, 3'b000, 1'b1, 3'd0, 1'b0);
      vecs[4] = mk(3'b001, 8'h5E, 3'b100, 8'h39, 3'b010, 8'h79, 12'hCED, 3'b000, 1'b0, 3'd0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_zero("reset_init");

      for (int r = 0; r < 5; r++) begin
         v0 = vcount;
         hold(vecs[r].dig[0], vecs[r].seg[0], 10);
         hold(vecs[r].dig[1], vecs[r].seg[1], 10);
         st = cyc;
         hold(vecs[r].dig[2], vecs[r].seg[2], 10);
         chk($sformatf("v%0d_valid_count", r), 32'(vcount - v0), 1);
         chk($sformatf("v%0d_latency", r), 32'(vcyc - st), 5);
         chk($sformatf("v%0d_data", r), 32'(data_out), 32'(vecs[r].data));
         chk($sformatf("v%0d_blank", r), 32'(blank_mask), 32'(vecs[r].blank));
         chk($sformatf("v%0d_dp", r), 32'(dp_present), 32'(vecs[r].dp));
         chk($sformatf("v%0d_loc", r), 32'(dp_location), 32'(vecs[r].loc));
         chk($sformatf("v%0d_perr", r), 32'(pattern_error), 32'(vecs[r].perr));
         hold(3'b000, 8'h00, 2);
      end

      v0 = vcount;
      hold(3'b001, 8'h06, 3);
      hold(3'b001, 8'h4F, 10);
      hold(3'b010, 8'h5B, 10);
      hold(3'b100, 8'h06, 10);
      chk("glitch_valid_count", 32'(vcount - v0), 1);
      chk("glitch_data", 32'(data_out), 32'h123);
      hold(3'b000, 8'h00, 2);

      hold(3'b010, 8'h5B, 10);
      hold(3'b100, 8'h06, 10);
      v0 = vcount;
      hold(3'b011, 8'h4F, 20);
      chk("two_hot_no_valid", 32'(vcount - v0), 0);
      hold(3'b001, 8'h66, 10);
      chk("two_hot_after_valid", 32'(vcount - v0), 1);
      chk("two_hot_after_data", 32'(data_out), 32'h124);
      hold(3'b000, 8'h00, 2);

      v0 = vcount;
      hold(3'b001, 8'h4F, 10);
      digit_in = '0;
      seg_in   = '0;
      for (int k = 0; k < 150 && !stale; k++) @(negedge clk);
      chk("timeout_stale", 32'(stale), 1);
      chk("timeout_no_valid", 32'(vcount - v0), 0);
      chk("timeout_data_kept", 32'(data_out), 32'h124);
      @(posedge clk);
      #1;
      hold(3'b010, 8'h7D, 10);
      hold(3'b100, 8'h07, 10);
      chk("timeout_mask_cleared", 32'(vcount - v0), 0);
      chk("timeout_stale_held", 32'(stale), 1);
      hold(3'b001, 8'h6D, 10);
      chk("recover_valid", 32'(vcount - v0), 1);
      chk("recover_data", 32'(data_out), 32'h765);
      chk("recover_stale", 32'(stale), 0);
      hold(3'b000, 8'h00, 2);

      v0 = vcount;
      hold(3'b001, 8'h3F, 10);
      hold(3'b010, 8'h06, 10);
      digit_in = '0;
      seg_in   = '0;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("reset_mid");
      rst = 1'b0;
      hold(3'b000, 8'h00, 2);
      hold(3'b100, 8'h4F, 10);
      hold(3'b001, 8'h66, 10);
      chk("reset_partial_no_valid", 32'(vcount - v0), 0);
      hold(3'b010, 8'h6D, 10);
      chk("reset_full_valid", 32'(vcount - v0), 1);
      chk("reset_full_data", 32'(data_out), 32'h354);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
